// File: rtl/video_pkg.sv
// video_pkg: shared widths, palette, pipeline stage type and the built-in glyph table
package video_pkg;
   localparam int ADDR_W = 11;
   localparam int RGB_W = 12;
   localparam logic [RGB_W-1:0] BLACK = '0;
   localparam logic [RGB_W-1:0] PALETTE [16] = '{
      12'h000, 12'hFFF, 12'h0F0, 12'hF00, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
      12'h888, 12'h444, 12'h800, 12'h080, 12'h008, 12'hF80, 12'h8F8, 12'hFFF
   };
   typedef struct packed {
      logic [3:0] color;
      logic       video_on;
      logic       hsync;
      logic       vsync;
      logic       blank;
      logic [2:0] col;
   } stage_t;
   localparam stage_t STAGE_RST = '{color: 4'h0, video_on: 1'b0, hsync: 1'b1,
                                    vsync: 1'b1, blank: 1'b0, col: 3'd0};
   // glyph rows indexed by {char[6:0], row[3:0]}; unlisted characters are empty
   function automatic logic [7:0] font_row(input logic [ADDR_W-1:0] a);
      return a[10:4] == 7'h00 ? 8'hFF :
             a[10:4] == 7'h30 ? (a[3:0] == 4'd5 ? 8'h80 : 8'h00) :
             a[10:4] == 7'h31 ? 8'h40 :
             a[10:4] == 7'h32 ? 8'hFF : 8'h00;
   endfunction
endpackage

// File: rtl/text_pixel_generator_if.sv
// text_pixel_generator_if: per-pixel overlay stream from the overlay logic to the pixel generator
interface text_pixel_generator_if;
   import video_pkg::*;
   logic [ADDR_W-1:0] rom_addr;
   logic [3:0]        color_addr;
   logic [1:0]        font_size;
   logic [9:0]        pixelx;
   logic              video_on;
   logic              hsync;
   logic              vsync;
   modport master (output rom_addr, color_addr, font_size, pixelx, video_on, hsync, vsync);
   modport slave  (input  rom_addr, color_addr, font_size, pixelx, video_on, hsync, vsync);
endinterface

// File: rtl/font_rom.sv
// font_rom: 2048x8 synchronous-read glyph ROM with clock enable and one cycle of latency
module font_rom
   import video_pkg::*;
(
   input  logic              clk,
   input  logic              ce,
   input  logic [ADDR_W-1:0] addr,
   output logic [7:0]        data
);
   always_ff @(posedge clk)
      if (ce) data <= font_row(addr);
endmodule

// File: rtl/text_pixel_generator.sv
// text_pixel_generator: font lookup, column select and palette mapping to registered VGA RGB
// with syncs delayed to match the two-tick pipeline.
module text_pixel_generator
   import video_pkg::*;
#(
   parameter int BLINK_FRAMES = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pixel_tick,
   text_pixel_generator_if.slave ov,
   output logic [RGB_W-1:0]     rgb,
   output logic                 hsync_o,
   output logic                 vsync_o
);
   localparam logic [5:0] LAST = 6'(BLINK_FRAMES - 1);
   stage_t     s1, s1_next;
   logic [7:0] font_word;
   logic [5:0] frame_cnt;
   logic       blink_phase, lit, on, vs_fall, unused_px;
   font_rom u_rom (.clk(clk), .ce(pixel_tick), .addr(ov.rom_addr), .data(font_word));
   assign s1_next = '{
      color:    ov.color_addr,
      video_on: ov.video_on,
      hsync:    ov.hsync,
      vsync:    ov.vsync,
      blank:    ov.rom_addr[10:4] == 7'h00,
      col:      ov.font_size == 2'd0 ? ov.pixelx[2:0] :
                ov.font_size == 2'd1 ? ov.pixelx[3:1] : ov.pixelx[4:2]
   };
   assign unused_px = ^ov.pixelx[9:5];
   assign lit = font_word[3'd7 - s1.col];
   assign on = s1.video_on & lit & ~s1.blank & ~(blink_phase & (s1.color == 4'hF));
   // vsync_o is the previous registered copy, so this sees the fall one stage in
   assign vs_fall = pixel_tick & vsync_o & ~s1.vsync;
   always_ff @(posedge clk or negedge reset)
      if (!reset) s1 <= STAGE_RST;
      else if (pixel_tick) s1 <= s1_next;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rgb <= BLACK;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
      end else if (pixel_tick) begin
         rgb <= on ? PALETTE[s1.color] : BLACK;
         hsync_o <= s1.hsync;
         vsync_o <= s1.vsync;
      end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         frame_cnt <= '0;
         blink_phase <= 1'b0;
      end else if (vs_fall) begin
         frame_cnt <= frame_cnt == LAST ? 6'd0 : frame_cnt + 6'd1;
         blink_phase <= frame_cnt == LAST ? ~blink_phase : blink_phase;
      end
endmodule
